// File: rtl/dmem_shadow_pkg.sv
// Shared types for the data-memory shadow model.
// Holds the ready FSM state encoding and the byte-lane merge helper.
package dmem_shadow_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    // One byte lane of a strobed write: take the new byte when enabled.
    function automatic logic [7:0] lane_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       en
    );
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/dmem_shadow_slot.sv
// One tracked word: shadow data, per-byte written mask, address compare.
// Ports: clock/reset, track_addr, mem_addr, wdata/wstrb/we in; match, data, mask out.
module dmem_shadow_slot
    import dmem_shadow_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [XLEN-1:0]   track_addr,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN/8-1:0] wstrb,
    input  logic              we,
    output logic              match,
    output logic [XLEN-1:0]   data,
    output logic [XLEN/8-1:0] mask
);

    localparam int NB = XLEN / 8;
    // Clears the byte-offset bits so both sides compare as word addresses.
    localparam logic [XLEN-1:0] AMASK = ~(XLEN'(NB - 1));

    assign match = (track_addr & AMASK) == (mem_addr & AMASK);

    always_ff @(posedge clock) begin
        if (reset) begin
            data <= '0;
            mask <= '0;
        end else if (we) begin
            for (int b = 0; b < NB; b++) begin
                data[b*8 +: 8] <= lane_merge(data[b*8 +: 8],
                                             wdata[b*8 +: 8], wstrb[b]);
            end
            mask <= mask | wstrb;
        end
    end

endmodule

// File: rtl/dmem_shadow_multi.sv
// Shadow model of NUM_WORDS data words on the core memory port, with ready generation.
// Ports: clock, reset, track_addr, ready_delay, mem_* in; mem_ready, exp_*, hit, *_err, rd_mismatch out.
module dmem_shadow_multi
    import dmem_shadow_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_WORDS = 4,
    parameter int MAX_WAIT  = 15,
    localparam int CW       = $clog2(MAX_WAIT + 2),
    localparam int NB       = XLEN / 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_WORDS*XLEN-1:0] track_addr,
    input  logic [CW-1:0]             ready_delay,
    input  logic                      mem_valid,
    input  logic [XLEN-1:0]           mem_addr,
    input  logic [XLEN-1:0]           mem_wdata,
    input  logic [NB-1:0]             mem_wstrb,
    input  logic [XLEN-1:0]           mem_rdata,
    output logic                      mem_ready,
    output logic [XLEN-1:0]           exp_rdata,
    output logic [NB-1:0]             exp_mask,
    output logic                      hit,
    output logic                      rd_mismatch,
    output logic                      proto_err,
    output logic                      stall_err
);

    localparam logic [CW-1:0] STALL_MAX = CW'(MAX_WAIT + 1);

    logic [NUM_WORDS-1:0] match;
    logic [NUM_WORDS-1:0] we;
    logic [XLEN-1:0]      slot_data [NUM_WORDS];
    logic [NB-1:0]        slot_mask [NUM_WORDS];

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   stall_cnt;
    logic [XLEN-1:0] cap_addr;
    logic [XLEN-1:0] cap_wdata;
    logic [NB-1:0]   cap_wstrb;

    logic fire;
    logic is_read;
    logic diff_any;

    // Zero-delay requests are acknowledged combinationally from IDLE.
    assign mem_ready = (state == ACK) ||
                       (mem_valid && state == IDLE && ready_delay == '0);
    assign fire      = mem_valid && mem_ready && !reset;
    assign is_read   = (mem_wstrb == '0);

    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_slot
        dmem_shadow_slot #(
            .XLEN (XLEN)
        ) u_slot (
            .clock      (clock),
            .reset      (reset),
            .track_addr (track_addr[i*XLEN +: XLEN]),
            .mem_addr   (mem_addr),
            .wdata      (mem_wdata),
            .wstrb      (mem_wstrb),
            .we         (we[i]),
            .match      (match[i]),
            .data       (slot_data[i]),
            .mask       (slot_mask[i])
        );
    end

    // Lowest matching slot owns the access; duplicates stay untouched.
    always_comb begin
        hit       = 1'b0;
        exp_rdata = '0;
        exp_mask  = '0;
        we        = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (match[i] && !hit) begin
                hit       = 1'b1;
                exp_rdata = slot_data[i];
                exp_mask  = slot_mask[i];
                we[i]     = fire;
            end
        end
    end

    // Only bytes already written are compared against the returned data.
    always_comb begin
        diff_any = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (exp_mask[b] && exp_rdata[b*8 +: 8] != mem_rdata[b*8 +: 8]) begin
                diff_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            stall_cnt   <= '0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            cap_wstrb   <= '0;
            rd_mismatch <= 1'b0;
            proto_err   <= 1'b0;
            stall_err   <= 1'b0;
        end else begin
            rd_mismatch <= fire && is_read && hit && diff_any;

            if (state == IDLE && mem_valid) begin
                cap_addr  <= mem_addr;
                cap_wdata <= mem_wdata;
                cap_wstrb <= mem_wstrb;
            end

            if (state != IDLE &&
                (!mem_valid || mem_addr != cap_addr ||
                 mem_wdata != cap_wdata || mem_wstrb != cap_wstrb)) begin
                proto_err <= 1'b1;
            end

            if (!mem_valid || fire) begin
                stall_cnt <= '0;
            end else if (stall_cnt != STALL_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
                if (stall_cnt == STALL_MAX - 1'b1) begin
                    stall_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (mem_valid && ready_delay != '0) begin
                        cnt   <= ready_delay;
                        state <= (ready_delay == CW'(1)) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (!mem_valid) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(2)) begin
                            state <= ACK;
                        end
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_shadow_multi.sv
// Scoreboard bench for dmem_shadow_multi.
// Drives transfers, predicts ready latency, shadow contents and mismatch pulses.
module tb_dmem_shadow_multi;

    logic         clock = 1'b0;
    logic         reset;
    logic [127:0] track_addr;
    logic [2:0]   ready_delay;
    logic         mem_valid;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_wstrb;
    logic [31:0]  mem_rdata;
    logic         mem_ready;
    logic [31:0]  exp_rdata;
    logic [3:0]   exp_mask;
    logic         hit;
    logic         rd_mismatch;
    logic         proto_err;
    logic         stall_err;

    always #5 clock = ~clock;

    logic [31:0] trk  [4];
    logic [31:0] mdat [4];
    logic [3:0]  mmsk [4];

    assign track_addr = {trk[3], trk[2], trk[1], trk[0]};

    typedef struct {
        logic        hit;
        logic [31:0] rdata;
        logic [3:0]  mask;
        logic        mism;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    dmem_shadow_multi #(
        .XLEN      (32),
        .NUM_WORDS (4),
        .MAX_WAIT  (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .track_addr  (track_addr),
        .ready_delay (ready_delay),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .exp_rdata   (exp_rdata),
        .exp_mask    (exp_mask),
        .hit         (hit),
        .rd_mismatch (rd_mismatch),
        .proto_err   (proto_err),
        .stall_err   (stall_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int lookup(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((trk[i] & ~32'h3) == (a & ~32'h3)) return i;
        end
        return -1;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            mdat[i] = '0;
            mmsk[i] = '0;
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] rd,
                        input logic [2:0] d);
        exp_t        e;
        exp_t        g;
        int          idx;
        logic [31:0] bm;
        int          cyc;
        bit          done;
        idx     = lookup(a);
        e.hit   = (idx >= 0);
        e.rdata = (idx >= 0) ? mdat[idx] : 32'h0;
        e.mask  = (idx >= 0) ? mmsk[idx] : 4'h0;
        bm = '0;
        for (int b = 0; b < 4; b++) begin
            if (e.mask[b]) bm[b*8 +: 8] = 8'hFF;
        end
        e.mism = (ws == 4'h0) && e.hit && (((e.rdata ^ rd) & bm) != 0);
        e.lat  = int'(d);
        sb.push_back(e);
        @(posedge clock); #1;
        mem_valid   = 1'b1;
        mem_addr    = a;
        mem_wdata   = wd;
        mem_wstrb   = ws;
        mem_rdata   = rd;
        ready_delay = d;
        cyc  = 0;
        done = 0;
        while (!done && cyc < 16) begin
            @(negedge clock);
            if (mem_ready) begin
                g = sb.pop_front();
                chk("lat", cyc, g.lat);
                chk("hit", hit, g.hit);
                chk("mask", exp_mask, g.mask);
                if (g.hit) chk("rdata", exp_rdata, g.rdata);
                done = 1;
            end
            @(posedge clock); #1;
            cyc++;
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        if (!done) begin
            chk("timeout", 0, 1);
            void'(sb.pop_front());
        end else if (ws != 4'h0 && idx >= 0) begin
            for (int b = 0; b < 4; b++) begin
                if (ws[b]) begin
                    mdat[idx][b*8 +: 8] = wd[b*8 +: 8];
                    mmsk[idx][b] = 1'b1;
                end
            end
        end
        @(negedge clock);
        if (done) chk("mism", rd_mismatch, g.mism);
        @(negedge clock);
        chk("mism_clr", rd_mismatch, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        bit seen;
        reset       = 1'b1;
        mem_valid   = 1'b0;
        mem_addr    = 32'h100;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        mem_rdata   = '0;
        ready_delay = '0;
        trk[0] = 32'h100;
        trk[1] = 32'h104;
        trk[2] = 32'h200;
        trk[3] = 32'h300;
        clear_model();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", mem_ready, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_stall", stall_err, 0);
        chk("rst_mism", rd_mismatch, 0);
        chk("rst_mask", exp_mask, 0);
        chk("rst_hit", hit, 1);

        xfer(32'h100, 32'hAABBCCDD, 4'hF, 32'h0, 3'd0);
        xfer(32'h100, 32'h0, 4'h0, 32'hAABBCCDD, 3'd2);
        xfer(32'h104, 32'h0000EE00, 4'b0010, 32'h0, 3'd1);
        xfer(32'h104, 32'h0, 4'h0, 32'h1234EE78, 3'd0);
        xfer(32'h104, 32'h0, 4'h0, 32'h1234EF78, 3'd3);
        xfer(32'h102, 32'h0, 4'h0, 32'hAABBCCDD, 3'd1);
        xfer(32'h400, 32'h55667788, 4'hF, 32'h0, 3'd1);

        trk[2] = 32'h100;
        xfer(32'h100, 32'h00000011, 4'b0001, 32'h0, 3'd0);
        trk[0] = 32'h500;
        xfer(32'h100, 32'h0, 4'h0, 32'h0, 3'd1);
        xfer(32'h500, 32'h0, 4'h0, 32'hAABBCC11, 3'd2);
        chk("stall_pre", stall_err, 0);
        chk("proto_pre", proto_err, 0);

        @(posedge clock); #1;
        mem_valid   = 1'b1;
        mem_addr    = 32'h300;
        mem_wstrb   = 4'h0;
        ready_delay = 3'd3;
        @(posedge clock); #1;
        mem_addr = 32'h304;
        @(negedge clock);
        chk("proto_lag", proto_err, 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("proto_set", proto_err, 1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (mem_ready) seen = 1;
            else begin
                @(posedge clock); #1;
                @(negedge clock);
            end
        end
        chk("proto_ready", seen, 1);
        @(posedge clock); #1;
        mem_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("proto_sticky", proto_err, 1);

        @(posedge clock); #1;
        mem_valid   = 1'b1;
        mem_addr    = 32'h300;
        ready_delay = 3'd6;
        seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clock);
            if (c == 4) chk("stall_c4", stall_err, 0);
            if (c == 5) chk("stall_c5", stall_err, 1);
            if (mem_ready) begin
                chk("stall_lat", c, 6);
                seen = 1;
            end
            @(posedge clock); #1;
        end
        chk("stall_ready", seen, 1);
        mem_valid = 1'b0;
        @(negedge clock);
        chk("stall_sticky", stall_err, 1);

        @(posedge clock); #1;
        mem_valid   = 1'b1;
        mem_addr    = 32'h104;
        mem_wdata   = 32'hDEADBEEF;
        mem_wstrb   = 4'hF;
        ready_delay = 3'd3;
        @(posedge clock); #1;
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(posedge clock); #1;
        reset = 1'b0;
        clear_model();
        @(negedge clock);
        chk("rr_ready", mem_ready, 0);
        chk("rr_proto", proto_err, 0);
        chk("rr_stall", stall_err, 0);
        chk("rr_mask104", exp_mask, 0);
        mem_addr = 32'h500;
        #1;
        chk("rr_mask500", exp_mask, 0);
        xfer(32'h104, 32'h0, 4'h0, 32'hDEADBEEF, 3'd0);
        xfer(32'h104, 32'h0, 4'h0, 32'h0, 3'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
